ft_commit_ctrl: RTL and testbench

- Commit sequencer between the lockstep comparator and the shared GPR (sgpr) write port.
- Compared writes are held in a DEPTH-entry delay window before they are released to sgpr.
- A mismatch squashes the whole window, blocks fetch for a fixed interval and issues a replay PC equal to the oldest unretired instruction.
- Replaces the direct comparator-to-sgpr write path.

---
 rtl/ft_commit_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ft_commit_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft_commit_ctrl.sv
// Commit sequencer: holds lockstep-compared GPR writes in a DEPTH-cycle window, squashes it on mismatch
// and issues a replay. Optional macro FT_RETRY_LIMIT_EN adds a consecutive-error limit with a sticky FAIL state.
module ft_commit_ctrl #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH        = 4,
    parameter int BLOCK_CYCLES = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_valid_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [PC_WIDTH-1:0]   wr_pc_i,
    input  logic                  error_i,
    output logic                  sgpr_we_o,
    output logic [ADDR_WIDTH-1:0] sgpr_waddr_o,
    output logic [DATA_WIDTH-1:0] sgpr_wdata_o,
    output logic                  fetch_block_o,
    output logic                  replay_valid_o,
    output logic [PC_WIDTH-1:0]   replay_pc_o,
    output logic [7:0]            err_cnt_o,
    output logic                  fatal_o
);

`ifdef FT_RETRY_LIMIT_EN
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_BLOCK = 2'd2, ST_FAIL = 2'd3} state_e;
`else
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_BLOCK = 2'd2} state_e;
`endif

    localparam int BC_W = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;

    state_e                state_q;
    logic [BC_W-1:0]       blk_cnt_q;
    logic [DEPTH-1:0]      win_vld_q;
    logic [ADDR_WIDTH-1:0] win_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] win_data_q [DEPTH];
    logic [PC_WIDTH-1:0]   win_pc_q   [DEPTH];
    logic                  sgpr_we_q;
    logic [ADDR_WIDTH-1:0] sgpr_waddr_q;
    logic [DATA_WIDTH-1:0] sgpr_wdata_q;
    logic                  fetch_block_q;
    logic                  replay_valid_q;
    logic [PC_WIDTH-1:0]   replay_pc_q;
    logic [7:0]            err_cnt_q;
    logic [PC_WIDTH-1:0]   replay_pc_d;
    logic                  run_s;
    logic                  err_acc_s;
    logic                  commit_s;

    assign run_s     = (state_q == ST_RUN);
    assign err_acc_s = run_s & error_i;
    assign commit_s  = run_s & win_vld_q[DEPTH-1];

    // Replay target: oldest valid entry surviving the shift-out (slot DEPTH-1 is committed, not replayed).
    always_comb begin
        replay_pc_d = wr_pc_i;
        for (int i = 0; i < DEPTH - 1; i++) begin
            replay_pc_d = win_vld_q[i] ? win_pc_q[i] : replay_pc_d;
        end
    end

`ifdef FT_RETRY_LIMIT_EN
    localparam int RC_W = $clog2(MAX_RETRY + 1);
    logic [RC_W-1:0] retry_q;
    logic [RC_W-1:0] retry_d;
    logic            fatal_q;
    logic            enter_fail_s;

    // Consecutive-error count: any commit restarts it, counting an error on that same edge.
    always_comb begin
        if (commit_s) begin
            retry_d = err_acc_s ? RC_W'(1) : '0;
        end else if (err_acc_s) begin
            retry_d = retry_q + RC_W'(1);
        end else begin
            retry_d = retry_q;
        end
    end

    assign enter_fail_s = err_acc_s & (retry_d >= RC_W'(MAX_RETRY));

    // Retry counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign fatal_o = fatal_q;
`else
    assign fatal_o = 1'b0;
`endif

    // Delay window: shifts in RUN; an error or any non-RUN state empties it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                win_addr_q[i] <= '0;
                win_data_q[i] <= '0;
                win_pc_q[i]   <= '0;
            end
        end else if (run_s && !error_i) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                win_vld_q[i]  <= win_vld_q[i-1];
                win_addr_q[i] <= win_addr_q[i-1];
                win_data_q[i] <= win_data_q[i-1];
                win_pc_q[i]   <= win_pc_q[i-1];
            end
            win_vld_q[0]  <= wr_valid_i & ~error_i;
            win_addr_q[0] <= wr_addr_i;
            win_data_q[0] <= wr_data_i;
            win_pc_q[0]   <= wr_pc_i;
        end else begin
            win_vld_q <= '0;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_RUN;
            blk_cnt_q      <= '0;
            sgpr_we_q      <= 1'b0;
            sgpr_waddr_q   <= '0;
            sgpr_wdata_q   <= '0;
            fetch_block_q  <= 1'b0;
            replay_valid_q <= 1'b0;
            replay_pc_q    <= '0;
            err_cnt_q      <= 8'd0;
`ifdef FT_RETRY_LIMIT_EN
            fatal_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    // The entry leaving the window predates any error now present, so it always commits.
                    sgpr_we_q    <= commit_s;
                    sgpr_waddr_q <= win_addr_q[DEPTH-1];
                    sgpr_wdata_q <= win_data_q[DEPTH-1];
                    if (error_i) begin
                        err_cnt_q     <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        fetch_block_q <= 1'b1;
`ifdef FT_RETRY_LIMIT_EN
                        if (enter_fail_s) begin
                            state_q        <= ST_FAIL;
                            fatal_q        <= 1'b1;
                            replay_valid_q <= 1'b0;
                        end else begin
                            state_q        <= ST_FLUSH;
                            replay_valid_q <= 1'b1;
                            replay_pc_q    <= replay_pc_d;
                        end
`else
                        state_q        <= ST_FLUSH;
                        replay_valid_q <= 1'b1;
                        replay_pc_q    <= replay_pc_d;
`endif
                    end else begin
                        state_q        <= ST_RUN;
                        fetch_block_q  <= 1'b0;
                        replay_valid_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_q        <= ST_BLOCK;
                    blk_cnt_q      <= BC_W'(BLOCK_CYCLES - 1);
                    sgpr_we_q      <= 1'b0;
                    fetch_block_q  <= 1'b1;
                    replay_valid_q <= 1'b0;
                end
                ST_BLOCK: begin
                    sgpr_we_q      <= 1'b0;
                    replay_valid_q <= 1'b0;
                    if (blk_cnt_q == '0) begin
                        state_q       <= ST_RUN;
                        fetch_block_q <= 1'b0;
                    end else begin
                        blk_cnt_q     <= blk_cnt_q - BC_W'(1);
                        fetch_block_q <= 1'b1;
                    end
                end
`ifdef FT_RETRY_LIMIT_EN
                ST_FAIL: begin
                    sgpr_we_q      <= 1'b0;
                    replay_valid_q <= 1'b0;
                    fetch_block_q  <= 1'b1;
                    fatal_q        <= 1'b1;
                end
`endif
                default: begin
                    state_q        <= ST_RUN;
                    sgpr_we_q      <= 1'b0;
                    fetch_block_q  <= 1'b0;
                    replay_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sgpr_we_o      = sgpr_we_q;
    assign sgpr_waddr_o   = sgpr_waddr_q;
    assign sgpr_wdata_o   = sgpr_wdata_q;
    assign fetch_block_o  = fetch_block_q;
    assign replay_valid_o = replay_valid_q;
    assign replay_pc_o    = replay_pc_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_ft_commit_ctrl.sv
// Self-checking bench for ft_commit_ctrl: cycle table for commit/flush/block, then directed sequences
// for empty-window replay, retry behaviour (FT_RETRY_LIMIT_EN aware) and async reset mid-block.
module tb_ft_commit_ctrl;
    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        error;
    logic        sgpr_we;
    logic [4:0]  sgpr_waddr;
    logic [31:0] sgpr_wdata;
    logic        fetch_block;
    logic        replay_valid;
    logic [31:0] replay_pc;
    logic [7:0]  err_cnt;
    logic        fatal;

    int checks;
    int failures;

    typedef struct {
        logic        wv;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_fb;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [7:0]  e_cnt;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    ft_commit_ctrl #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .PC_WIDTH(32),
        .DEPTH(4), .BLOCK_CYCLES(8), .MAX_RETRY(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_pc_i(wr_pc), .error_i(error),
        .sgpr_we_o(sgpr_we), .sgpr_waddr_o(sgpr_waddr), .sgpr_wdata_o(sgpr_wdata),
        .fetch_block_o(fetch_block), .replay_valid_o(replay_valid), .replay_pc_o(replay_pc),
        .err_cnt_o(err_cnt), .fatal_o(fatal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic e);
        wr_valid = wv;
        wr_addr  = a;
        wr_data  = d;
        wr_pc    = pc;
        error    = e;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (fetch_block && n < 20) begin
            tick();
            n++;
        end
        check("wait_run_fetch_block", {31'd0, fetch_block}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, {31'd0, sgpr_we}, 32'd0);
        check({tag, "_fb"}, {31'd0, fetch_block}, 32'd0);
        check({tag, "_rv"}, {31'd0, replay_valid}, 32'd0);
        check({tag, "_rpc"}, replay_pc, 32'd0);
        check({tag, "_cnt"}, {24'd0, err_cnt}, 32'd0);
        check({tag, "_fatal"}, {31'd0, fatal}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < NVEC; i++) tbl[i] = '{default: '0};
        tbl[0].wv = 1'b1; tbl[0].addr = 5'd3; tbl[0].data = 32'hA5A5A5A5; tbl[0].pc = 32'h10;
        tbl[1].wv = 1'b1; tbl[1].addr = 5'd7; tbl[1].data = 32'h1234;     tbl[1].pc = 32'h14;
        tbl[4].e_we = 1'b1; tbl[4].e_addr = 5'd3; tbl[4].e_data = 32'hA5A5A5A5;
        tbl[5].e_we = 1'b1; tbl[5].e_addr = 5'd7; tbl[5].e_data = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            tbl[7+k].wv   = 1'b1;
            tbl[7+k].addr = 5'(k + 1);
            tbl[7+k].data = 32'(32'h11 * (k + 1));
            tbl[7+k].pc   = 32'(32'h100 + 4 * k);
        end
        tbl[11].wv = 1'b1; tbl[11].addr = 5'd5; tbl[11].data = 32'h55; tbl[11].pc = 32'h110; tbl[11].err = 1'b1;
        tbl[11].e_we = 1'b1; tbl[11].e_addr = 5'd1; tbl[11].e_data = 32'h11; tbl[11].e_rv = 1'b1;
        for (int i = 11; i < NVEC; i++) begin
            tbl[i].e_rpc = 32'h104;
            tbl[i].e_cnt = 8'd1;
        end
        for (int i = 11; i < 20; i++) tbl[i].e_fb = 1'b1;
        for (int i = 13; i < 15; i++) begin
            tbl[i].wv = 1'b1; tbl[i].addr = 5'd9; tbl[i].data = 32'h99; tbl[i].pc = 32'h300; tbl[i].err = 1'b1;
        end

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].wv, tbl[i].addr, tbl[i].data, tbl[i].pc, tbl[i].err);
            tick();
            check($sformatf("row%0d_we", i), {31'd0, sgpr_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                check($sformatf("row%0d_waddr", i), {27'd0, sgpr_waddr}, {27'd0, tbl[i].e_addr});
                check($sformatf("row%0d_wdata", i), sgpr_wdata, tbl[i].e_data);
            end
            check($sformatf("row%0d_fb", i), {31'd0, fetch_block}, {31'd0, tbl[i].e_fb});
            check($sformatf("row%0d_rv", i), {31'd0, replay_valid}, {31'd0, tbl[i].e_rv});
            check($sformatf("row%0d_rpc", i), replay_pc, tbl[i].e_rpc);
            check($sformatf("row%0d_cnt", i), {24'd0, err_cnt}, {24'd0, tbl[i].e_cnt});
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

        // Error with an empty window replays the error cycle's own PC.
        drive(1'b0, 5'd0, 32'd0, 32'h200, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("empty_rv", {31'd0, replay_valid}, 32'd1);
        check("empty_rpc", replay_pc, 32'h200);
        check("empty_cnt", {24'd0, err_cnt}, 32'd2);
        check("empty_fb", {31'd0, fetch_block}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("empty_nowe%0d", i), {31'd0, sgpr_we}, 32'd0);
            tick();
        end
        wait_run();

        // A commit between errors restarts the consecutive-error count.
        drive(1'b1, 5'd10, 32'hAB, 32'h400, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("w2_early%0d", i), {31'd0, sgpr_we}, 32'd0);
        end
        tick();
        check("w2_we", {31'd0, sgpr_we}, 32'd1);
        check("w2_waddr", {27'd0, sgpr_waddr}, 32'd10);
        check("w2_wdata", sgpr_wdata, 32'hAB);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'h500, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("e3_rv", {31'd0, replay_valid}, 32'd1);
        check("e3_rpc", replay_pc, 32'h500);
        check("e3_fatal", {31'd0, fatal}, 32'd0);
        check("e3_cnt", {24'd0, err_cnt}, 32'd3);
        wait_run();
        drive(1'b0, 5'd0, 32'd0, 32'h510, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("e4_rv", {31'd0, replay_valid}, 32'd1);
        check("e4_fatal", {31'd0, fatal}, 32'd0);
        wait_run();
        drive(1'b0, 5'd0, 32'd0, 32'h520, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("e5_cnt", {24'd0, err_cnt}, 32'd5);
`ifdef FT_RETRY_LIMIT_EN
        check("e5_fatal", {31'd0, fatal}, 32'd1);
        check("e5_rv", {31'd0, replay_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fail_fb%0d", i), {31'd0, fetch_block}, 32'd1);
            check($sformatf("fail_fatal%0d", i), {31'd0, fatal}, 32'd1);
            check($sformatf("fail_we%0d", i), {31'd0, sgpr_we}, 32'd0);
            tick();
        end
`else
        check("e5_fatal", {31'd0, fatal}, 32'd0);
        check("e5_rv", {31'd0, replay_valid}, 32'd1);
        check("e5_rpc", replay_pc, 32'h520);
        tick();
        tick();
        check("e5_block_fb", {31'd0, fetch_block}, 32'd1);
`endif

        // Asynchronous reset between clock edges clears everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_fb", {31'd0, fetch_block}, 32'd0);
        check("post_rst_cnt", {24'd0, err_cnt}, 32'd0);

        drive(1'b1, 5'd2, 32'hCAFE, 32'h600, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_early", {31'd0, sgpr_we}, 32'd0);
        tick();
        check("post_rst_we", {31'd0, sgpr_we}, 32'd1);
        check("post_rst_waddr", {27'd0, sgpr_waddr}, 32'd2);
        check("post_rst_wdata", sgpr_wdata, 32'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
